// File: rtl/fetch_pc_unit.sv
// PC register, next-PC selection and instruction-fetch control for the front of the datapath.
// Define FETCH_PERF_CNT_EN to add the FetchCount/StallCount performance counter outputs.
module fetch_pc_unit #(
    parameter logic [63:0] START_PC = 64'h0
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        Run,
    output logic        ImemReq,
    output logic [63:0] ImemAddr,
    input  logic        ImemAck,
    input  logic [31:0] ImemData,
    output logic [31:0] Instr,
    output logic [25:0] Imm25,
    output logic [63:0] CurPC,
    output logic        InstrValid,
    input  logic        InstrReady,
    input  logic [63:0] BusImm,
    input  logic        Branch,
    input  logic        Uncondbranch,
    input  logic        Zero,
    output logic        MisalignErr
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] FetchCount,
    output logic [31:0] StallCount
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD,
        HALT
    } stateT;

    stateT       state, stateNext;
    logic [63:0] pc, pcNext;
    logic [31:0] instrNext;
    logic [63:0] curPcNext;
    logic        misalignNext;
    logic [63:0] target;
    logic        accept;
    logic        stall;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            pc          <= START_PC;
            Instr       <= '0;
            CurPC       <= START_PC;
            MisalignErr <= 1'b0;
        end else begin
            state       <= stateNext;
            pc          <= pcNext;
            Instr       <= instrNext;
            CurPC       <= curPcNext;
            MisalignErr <= misalignNext;
        end
    end

    always_comb begin
        stateNext    = state;
        pcNext       = pc;
        instrNext    = Instr;
        curPcNext    = CurPC;
        misalignNext = MisalignErr;
        target       = CurPC + 64'd4;
        accept       = 1'b0;
        stall        = 1'b0;
        case (state)
            IDLE: begin
                if (Run) stateNext = FETCH;
            end
            FETCH: begin
                if (ImemAck) begin
                    instrNext = ImemData;
                    curPcNext = pc;
                    stateNext = HOLD;
                end else begin
                    stall = 1'b1;
                end
            end
            HOLD: begin
                if (InstrReady) begin
                    accept = 1'b1;
                    // Branch controls are only meaningful here, at the accept edge
                    if (Uncondbranch | (Branch & Zero)) target = CurPC + BusImm;
                    if (target[1:0] != 2'b00) begin
                        misalignNext = 1'b1;
                        stateNext    = HALT;
                    end else begin
                        pcNext    = target;
                        stateNext = Run ? FETCH : IDLE;
                    end
                end
            end
            HALT: begin
                stateNext = HALT;
            end
            default: stateNext = IDLE;
        endcase
    end

    assign ImemReq    = (state == FETCH);
    assign InstrValid = (state == HOLD);
    assign ImemAddr   = pc;
    assign Imm25      = Instr[25:0];

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            FetchCount <= '0;
            StallCount <= '0;
        end else begin
            if (accept && (FetchCount != '1)) FetchCount <= FetchCount + 32'd1;
            if (stall && (StallCount != '1)) StallCount <= StallCount + 32'd1;
        end
    end
`else
    logic unusedPerf;
    assign unusedPerf = accept ^ stall;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: captured fetches are queued and checked when presented.
module tb_fetch_pc_unit;

    localparam logic [63:0] START = 64'h0;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        Run;
    logic        ImemReq;
    logic [63:0] ImemAddr;
    logic        ImemAck;
    logic [31:0] ImemData;
    logic [31:0] Instr;
    logic [25:0] Imm25;
    logic [63:0] CurPC;
    logic        InstrValid;
    logic        InstrReady;
    logic [63:0] BusImm;
    logic        Branch;
    logic        Uncondbranch;
    logic        Zero;
    logic        MisalignErr;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] FetchCount;
    logic [31:0] StallCount;
`endif

    fetch_pc_unit #(.START_PC(START)) dut (
        .CLK(CLK),
        .Reset(Reset),
        .Run(Run),
        .ImemReq(ImemReq),
        .ImemAddr(ImemAddr),
        .ImemAck(ImemAck),
        .ImemData(ImemData),
        .Instr(Instr),
        .Imm25(Imm25),
        .CurPC(CurPC),
        .InstrValid(InstrValid),
        .InstrReady(InstrReady),
        .BusImm(BusImm),
        .Branch(Branch),
        .Uncondbranch(Uncondbranch),
        .Zero(Zero),
        .MisalignErr(MisalignErr)
`ifdef FETCH_PERF_CNT_EN
        ,
        .FetchCount(FetchCount),
        .StallCount(StallCount)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [63:0] addr;
        logic [31:0] data;
    } expT;

    expT         sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [63:0] modelPc;
    logic        modelMis;

    task automatic scrambleControls();
        Branch       = 1'($urandom);
        Uncondbranch = 1'($urandom);
        Zero         = 1'($urandom);
        BusImm       = {$urandom, $urandom};
    endtask

    task automatic applyReset(input string tag);
        #2 Reset = 1'b1;
        #1;
        checks++;
        if (ImemReq !== 1'b0 || InstrValid !== 1'b0 || Instr !== 32'h0 || CurPC !== START ||
            ImemAddr !== START || MisalignErr !== 1'b0) begin
            errors++;
            $display("FAIL reset_%s req=%b valid=%b instr=%h curpc=%h addr=%h mis=%b required 0 0 0 %h %h 0",
                     tag, ImemReq, InstrValid, Instr, CurPC, ImemAddr, MisalignErr, START, START);
        end
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (FetchCount !== 32'h0 || StallCount !== 32'h0) begin
            errors++;
            $display("FAIL reset_counters_%s fetch=%0d stall=%0d required 0 0", tag, FetchCount, StallCount);
        end
`endif
        ImemAck    = 1'b0;
        InstrReady = 1'b0;
        @(negedge CLK);
        Reset    = 1'b0;
        modelPc  = START;
        modelMis = 1'b0;
        sb.delete();
    endtask

    // One full instruction: wait for request, answer after ackDelay, accept after readyDelay.
    task automatic doInstr(input int ackDelay, input int readyDelay, input logic br, input logic ub,
                           input logic z, input logic [63:0] imm, input logic runInFetch,
                           input logic runInHold, output int waitCycles);
        logic [31:0] data;
        logic [63:0] nxt;
        expT         e;
        waitCycles = 0;
        while (ImemReq !== 1'b1 && waitCycles < 20) begin
            @(negedge CLK);
            waitCycles++;
        end
        checks++;
        if (ImemReq !== 1'b1) begin
            errors++;
            $display("FAIL req_timeout ImemReq=%b required 1", ImemReq);
            return;
        end
        checks++;
        if (ImemAddr !== modelPc) begin
            errors++;
            $display("FAIL fetch_addr got %h required %h", ImemAddr, modelPc);
        end
        Run  = runInFetch;
        data = $urandom;
        for (int i = 0; i < ackDelay; i++) begin
            ImemAck  = 1'b0;
            ImemData = $urandom;
            @(negedge CLK);
            checks++;
            if (ImemReq !== 1'b1 || InstrValid !== 1'b0 || ImemAddr !== modelPc) begin
                errors++;
                $display("FAIL fetch_stable req=%b valid=%b addr=%h required 1 0 %h",
                         ImemReq, InstrValid, ImemAddr, modelPc);
            end
        end
        ImemAck  = 1'b1;
        ImemData = data;
        e.addr   = modelPc;
        e.data   = data;
        sb.push_back(e);
        @(negedge CLK);
        ImemAck  = 1'b0;
        ImemData = $urandom;
        checks++;
        if (InstrValid !== 1'b1 || ImemReq !== 1'b0) begin
            errors++;
            $display("FAIL hold_entry valid=%b req=%b required 1 0", InstrValid, ImemReq);
        end
        e = sb.pop_front();
        checks++;
        if (Instr !== e.data || CurPC !== e.addr || Imm25 !== e.data[25:0]) begin
            errors++;
            $display("FAIL instr_capture instr=%h curpc=%h imm25=%h required %h %h %h",
                     Instr, CurPC, Imm25, e.data, e.addr, e.data[25:0]);
        end
        for (int i = 0; i < readyDelay; i++) begin
            InstrReady = 1'b0;
            scrambleControls();
            @(negedge CLK);
            checks++;
            if (InstrValid !== 1'b1 || Instr !== e.data || CurPC !== e.addr || ImemAddr !== modelPc ||
                ImemReq !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable valid=%b instr=%h curpc=%h addr=%h required 1 %h %h %h",
                         InstrValid, Instr, CurPC, ImemAddr, e.data, e.addr, modelPc);
            end
        end
        InstrReady   = 1'b1;
        Branch       = br;
        Uncondbranch = ub;
        Zero         = z;
        BusImm       = imm;
        Run          = runInHold;
        nxt = (ub | (br & z)) ? e.addr + imm : e.addr + 64'd4;
        if (nxt[1:0] != 2'b00) modelMis = 1'b1;
        else modelPc = nxt;
        @(negedge CLK);
        InstrReady = 1'b0;
        scrambleControls();
        checks++;
        if (MisalignErr !== modelMis) begin
            errors++;
            $display("FAIL misalign got %b required %b", MisalignErr, modelMis);
        end
        checks++;
        if (ImemAddr !== modelPc) begin
            errors++;
            $display("FAIL next_pc got %h required %h", ImemAddr, modelPc);
        end
    endtask

    task automatic test_reset();
        Run = 1'b0;
        @(negedge CLK);
        applyReset("initial");
        repeat (3) @(negedge CLK);
        checks++;
        if (ImemReq !== 1'b0 || ImemAddr !== START) begin
            errors++;
            $display("FAIL idle_no_req req=%b addr=%h required 0 %h", ImemReq, ImemAddr, START);
        end
    endtask

    task automatic test_sequential();
        int w;
        Run = 1'b1;
        for (int i = 0; i < 6; i++) begin
            doInstr(0, 0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1, w);
            checks++;
            if (i > 0 && w != 0) begin
                errors++;
                $display("FAIL throughput instr %0d waited %0d required 0", i, w);
            end
        end
        checks++;
        if (ImemAddr !== 64'h18) begin
            errors++;
            $display("FAIL seq_addr got %h required %h", ImemAddr, 64'h18);
        end
    endtask

    task automatic test_uncond_branch();
        int w;
        doInstr(0, 0, 1'b0, 1'b1, 1'b0, 64'h28, 1'b1, 1'b1, w);
        doInstr(0, 0, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF0, 1'b1, 1'b1, w);
        checks++;
        if (ImemAddr !== 64'h30) begin
            errors++;
            $display("FAIL uncond_back got %h required %h", ImemAddr, 64'h30);
        end
    endtask

    task automatic test_cond_branch();
        int w;
        doInstr(0, 0, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFD8, 1'b1, 1'b1, w);
        doInstr(0, 0, 1'b1, 1'b0, 1'b0, 64'h100, 1'b1, 1'b1, w);
        checks++;
        if (ImemAddr !== 64'hC) begin
            errors++;
            $display("FAIL cond_not_taken got %h required %h", ImemAddr, 64'hC);
        end
        doInstr(0, 0, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b1, w);
        doInstr(0, 0, 1'b1, 1'b0, 1'b1, 64'h100, 1'b1, 1'b1, w);
        checks++;
        if (ImemAddr !== 64'h108) begin
            errors++;
            $display("FAIL cond_taken got %h required %h", ImemAddr, 64'h108);
        end
        doInstr(0, 0, 1'b0, 1'b0, 1'b1, 64'h100, 1'b1, 1'b1, w);
        checks++;
        if (ImemAddr !== 64'h10C) begin
            errors++;
            $display("FAIL zero_no_branch got %h required %h", ImemAddr, 64'h10C);
        end
    endtask

    task automatic test_stall();
        int w;
        Run = 1'b1;
        applyReset("stall");
        doInstr(3, 2, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1, w);
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (StallCount !== 32'd3 || FetchCount !== 32'd1) begin
            errors++;
            $display("FAIL perf_counts stall=%0d fetch=%0d required 3 1", StallCount, FetchCount);
        end
`endif
    endtask

    task automatic test_run_control();
        int w;
        doInstr(2, 0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, w);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            checks++;
            if (ImemReq !== 1'b0 || InstrValid !== 1'b0) begin
                errors++;
                $display("FAIL run_stop req=%b valid=%b required 0 0", ImemReq, InstrValid);
            end
        end
        Run = 1'b1;
        doInstr(0, 1, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1, w);
        checks++;
        if (w != 1) begin
            errors++;
            $display("FAIL run_restart waited %0d required 1", w);
        end
    endtask

    task automatic test_wrap_misalign();
        int w;
        doInstr(0, 0, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC - modelPc, 1'b1, 1'b1, w);
        doInstr(0, 0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1, w);
        checks++;
        if (ImemAddr !== 64'h0) begin
            errors++;
            $display("FAIL pc_wrap got %h required %h", ImemAddr, 64'h0);
        end
        doInstr(0, 0, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b1, w);
        doInstr(0, 0, 1'b1, 1'b0, 1'b1, 64'h2, 1'b1, 1'b1, w);
        for (int i = 0; i < 8; i++) begin
            ImemAck = 1'($urandom);
            InstrReady = 1'b1;
            @(negedge CLK);
            checks++;
            if (ImemReq !== 1'b0 || InstrValid !== 1'b0 || MisalignErr !== 1'b1 ||
                ImemAddr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
                errors++;
                $display("FAIL halt req=%b valid=%b mis=%b addr=%h required 0 0 1 fffffffffffffffc",
                         ImemReq, InstrValid, MisalignErr, ImemAddr);
            end
        end
        applyReset("after_halt");
        doInstr(0, 0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1, w);
    endtask

    task automatic test_reset_mid();
        int w;
        doInstr(0, 0, 1'b0, 1'b1, 1'b0, 64'h1000, 1'b1, 1'b1, w);
        checks++;
        if (ImemReq !== 1'b1) begin
            errors++;
            $display("FAIL mid_fetch_setup req=%b required 1", ImemReq);
        end
        applyReset("mid_fetch");
        doInstr(0, 0, 1'b0, 1'b1, 1'b0, 64'h2000, 1'b1, 1'b1, w);
        ImemAck  = 1'b1;
        ImemData = 32'hDEAD_BEEF;
        @(negedge CLK);
        ImemAck = 1'b0;
        checks++;
        if (InstrValid !== 1'b1 || Instr !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL mid_hold_setup valid=%b instr=%h required 1 deadbeef", InstrValid, Instr);
        end
        applyReset("mid_hold");
        doInstr(1, 1, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1, w);
    endtask

    initial begin
        Reset        = 1'b1;
        Run          = 1'b0;
        ImemAck      = 1'b0;
        ImemData     = '0;
        InstrReady   = 1'b0;
        BusImm       = '0;
        Branch       = 1'b0;
        Uncondbranch = 1'b0;
        Zero         = 1'b0;
        modelPc      = START;
        modelMis     = 1'b0;
        test_reset();
        test_sequential();
        test_uncond_branch();
        test_cond_branch();
        test_stall();
        test_run_control();
        test_wrap_misalign();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
